// File: rtl/i4002_ram_if.sv
// MCS-4 RAM bank bus: CPU-side timing/command strobes, the shared 4-bit data bus and the output port.
interface i4002_ram_if;
    logic       sync;
    logic       cl_ram;
    logic       cm_ram;
    logic [3:0] dbus_in;
    logic [3:0] dbus_out;
    logic [3:0] io_out;

    modport master (
        output sync,
        output cl_ram,
        output cm_ram,
        output dbus_in,
        input  dbus_out,
        input  io_out
    );

    modport slave (
        input  sync,
        input  cl_ram,
        input  cm_ram,
        input  dbus_in,
        output dbus_out,
        output io_out
    );
endinterface

// File: rtl/i4002_ram.sv
// i4002 data RAM: 4x16 main + 4x4 status nibbles and a 4-bit output port, driven by the MCS-4 bus.
// Optional host readback port enabled by defining I4002_DBG_EN.
module i4002_ram #(
    parameter logic [1:0] CHIP_ID   = 2'b00,
    parameter logic [3:0] OUT_RESET = 4'h0
) (
    input  logic       clk,
    input  logic       rst,
    i4002_ram_if.slave bus
`ifdef I4002_DBG_EN
    ,
    input  logic [6:0] dbg_addr,
    output logic [3:0] dbg_data
`endif
);

    typedef enum logic [2:0] {
        PhA1, PhA2, PhA3, PhM1, PhM2, PhX1, PhX2, PhX3
    } phase_e;

    phase_e     phase_q, phase_d;
    logic       is_m2, is_x2, is_x3;

    logic       selected_q, selected_d;
    logic [1:0] reg_sel_q, reg_sel_d;
    logic [3:0] char_sel_q, char_sel_d;
    logic       src_pend_q, src_pend_d;
    logic       io_cmd_q, io_cmd_d;
    logic [3:0] opa_q, opa_d;
    logic [3:0] io_out_q, io_out_d;

    logic [3:0] main_q   [4][16];
    logic [3:0] status_q [4][4];

    logic       exec, wr_main, wr_stat, wr_port, rd_main, rd_stat;

    // Phase tracking: sync in X3 realigns the next cycle to A1.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= PhA1;
        end else begin
            phase_q <= phase_d;
        end
    end

    always_comb begin
        phase_d = bus.sync ? PhA1 : phase_e'(phase_q + 3'd1);
    end

    always_comb begin
        is_m2 = (phase_q == PhM2);
        is_x2 = (phase_q == PhX2);
        is_x3 = (phase_q == PhX3);
    end

    // CM at X2 marks an SRC, which takes precedence over any I/O command latched at M2.
    always_comb begin
        exec    = is_x2 && io_cmd_q && selected_q && !bus.cm_ram;
        wr_main = exec && (opa_q == 4'h0);
        wr_port = exec && (opa_q == 4'h1) && !bus.cl_ram;
        wr_stat = exec && (opa_q[3:2] == 2'b01);
        rd_main = exec && ((opa_q == 4'h8) || (opa_q == 4'h9) || (opa_q == 4'hB));
        rd_stat = exec && (opa_q[3:2] == 2'b11);
    end

    always_comb begin
        selected_d = selected_q;
        reg_sel_d  = reg_sel_q;
        char_sel_d = char_sel_q;
        src_pend_d = 1'b0;
        io_cmd_d   = io_cmd_q;
        opa_d      = opa_q;
        io_out_d   = io_out_q;
        if (is_x2 && bus.cm_ram) begin
            selected_d = (bus.dbus_in[3:2] == CHIP_ID);
            reg_sel_d  = bus.dbus_in[1:0];
            src_pend_d = 1'b1;
        end
        if (is_x3 && src_pend_q) begin
            char_sel_d = bus.dbus_in;
        end
        if (is_m2) begin
            io_cmd_d = bus.cm_ram;
            opa_d    = bus.dbus_in;
        end
        if (wr_port) begin
            io_out_d = bus.dbus_in;
        end
        if (bus.cl_ram) begin
            io_out_d   = OUT_RESET;
            selected_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            selected_q <= 1'b0;
            reg_sel_q  <= 2'd0;
            char_sel_q <= 4'd0;
            src_pend_q <= 1'b0;
            io_cmd_q   <= 1'b0;
            opa_q      <= 4'd0;
            io_out_q   <= OUT_RESET;
        end else begin
            selected_q <= selected_d;
            reg_sel_q  <= reg_sel_d;
            char_sel_q <= char_sel_d;
            src_pend_q <= src_pend_d;
            io_cmd_q   <= io_cmd_d;
            opa_q      <= opa_d;
            io_out_q   <= io_out_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 16; c++) begin
                    main_q[r][c] <= 4'd0;
                end
                for (int s = 0; s < 4; s++) begin
                    status_q[r][s] <= 4'd0;
                end
            end
        end else begin
            if (wr_main) begin
                main_q[reg_sel_q][char_sel_q] <= bus.dbus_in;
            end
            if (wr_stat) begin
                status_q[reg_sel_q][opa_q[1:0]] <= bus.dbus_in;
            end
        end
    end

    always_comb begin
        bus.dbus_out = 4'd0;
        if (rd_main) begin
            bus.dbus_out = main_q[reg_sel_q][char_sel_q];
        end else if (rd_stat) begin
            bus.dbus_out = status_q[reg_sel_q][opa_q[1:0]];
        end
    end

    assign bus.io_out = io_out_q;

`ifdef I4002_DBG_EN
    logic [3:0] dbg_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            dbg_data_q <= 4'd0;
        end else if (dbg_addr[6]) begin
            dbg_data_q <= status_q[dbg_addr[3:2]][dbg_addr[1:0]];
        end else begin
            dbg_data_q <= main_q[dbg_addr[5:4]][dbg_addr[3:0]];
        end
    end

    assign dbg_data = dbg_data_q;
`endif

endmodule

// File: tb/tb_i4002_ram.sv
// Bench for i4002_ram: directed instruction table, sync/reset corner sequences, then random
// instruction streams checked against an instruction-level model of the RAM chip.
module tb_i4002_ram;
    localparam logic [1:0] CHIP_ID   = 2'b00;
    localparam logic [3:0] OUT_RESET = 4'h6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    i4002_ram_if bus_if ();

    i4002_ram #(
        .CHIP_ID   (CHIP_ID),
        .OUT_RESET (OUT_RESET)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [3:0] dbus_seen;

    typedef struct {
        string      name;
        logic       cm_m2;
        logic [3:0] opa;
        logic       cm_x2;
        logic [3:0] x2;
        logic [3:0] x3;
        int         clr_ph;
        logic [3:0] exp_dbus;
        logic [3:0] exp_io;
    } vec_t;

    vec_t vecs[$];

    // Instruction-level reference state.
    logic [3:0] m_main [4][16];
    logic [3:0] m_stat [4][4];
    logic [3:0] m_io;
    logic       m_sel;
    logic [1:0] m_reg;
    logic [3:0] m_chr;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One bus cycle: drive at posedge+1, sample dbus_out at negedge.
    task automatic step(input logic s, input logic cl, input logic cm, input logic [3:0] d,
                        input logic r);
        bus_if.sync    = s;
        bus_if.cl_ram  = cl;
        bus_if.cm_ram  = cm;
        bus_if.dbus_in = d;
        rst            = r;
        @(negedge clk);
        dbus_seen = bus_if.dbus_out;
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input string name, input logic cm_m2, input logic [3:0] opa,
                         input logic cm_x2, input logic [3:0] x2, input logic [3:0] x3,
                         input int clr_ph, input logic sync_en, input logic [3:0] exp_dbus);
        logic [3:0] other;
        logic [3:0] at_x2;
        other = 4'd0;
        at_x2 = 4'd0;
        for (int p = 0; p < 8; p++) begin
            logic [3:0] d;
            logic       cm;
            d = 4'($urandom_range(0, 15));
            if (p == 4) d = opa;
            else if (p == 6) d = x2;
            else if (p == 7) d = x3;
            cm = (p == 4 && cm_m2) || (p == 6 && cm_x2);
            step((p == 7) && sync_en, clr_ph == p, cm, d, 1'b0);
            if (p == 6) at_x2 = dbus_seen;
            else other = other | dbus_seen;
        end
        check({name, " dbus@X2"}, at_x2, exp_dbus);
        check({name, " dbus idle"}, other, 4'h0);
    endtask

    function automatic vec_t mk(input string name, input logic cm_m2, input logic [3:0] opa,
                                input logic cm_x2, input logic [3:0] x2, input logic [3:0] x3,
                                input int clr_ph, input logic [3:0] exp_dbus,
                                input logic [3:0] exp_io);
        vec_t v;
        v.name = name; v.cm_m2 = cm_m2; v.opa = opa; v.cm_x2 = cm_x2; v.x2 = x2; v.x3 = x3;
        v.clr_ph = clr_ph; v.exp_dbus = exp_dbus; v.exp_io = exp_io;
        return v;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 16; c++) m_main[r][c] = 4'd0;
            for (int s = 0; s < 4; s++) m_stat[r][s] = 4'd0;
        end
        m_io  = OUT_RESET;
        m_sel = 1'b0;
        m_reg = 2'd0;
        m_chr = 4'd0;
    endtask

    // Whole-instruction effect: optional clear at A1, then either SRC or an I/O command.
    task automatic model_instr(input logic cm_m2, input logic [3:0] opa, input logic cm_x2,
                               input logic [3:0] x2, input logic [3:0] x3, input logic clr_a1,
                               output logic [3:0] exp_dbus);
        exp_dbus = 4'd0;
        if (clr_a1) begin
            m_io  = OUT_RESET;
            m_sel = 1'b0;
        end
        if (cm_x2) begin
            m_sel = (x2[3:2] == CHIP_ID);
            m_reg = x2[1:0];
            m_chr = x3;
        end else if (cm_m2 && m_sel) begin
            case (opa)
                4'h0: m_main[m_reg][m_chr] = x2;
                4'h1: m_io = x2;
                4'h4, 4'h5, 4'h6, 4'h7: m_stat[m_reg][opa - 4'h4] = x2;
                4'h8, 4'h9, 4'hB: exp_dbus = m_main[m_reg][m_chr];
                4'hC, 4'hD, 4'hE, 4'hF: exp_dbus = m_stat[m_reg][opa - 4'hC];
                default: ;
            endcase
        end
    endtask

    initial begin
        bus_if.sync    = 1'b0;
        bus_if.cl_ram  = 1'b0;
        bus_if.cm_ram  = 1'b0;
        bus_if.dbus_in = 4'd0;
        rst            = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset io_out", bus_if.io_out, OUT_RESET);
        check("reset dbus_out", bus_if.dbus_out, 4'h0);

        vecs.push_back(mk("src 0/0",      0, 4'h0, 1, 4'h0, 4'h0, -1, 4'h0, OUT_RESET));
        vecs.push_back(mk("rdm fresh",    1, 4'h9, 0, 4'hF, 4'h0, -1, 4'h0, OUT_RESET));
        vecs.push_back(mk("src 1/5",      0, 4'h0, 1, 4'h1, 4'h5, -1, 4'h0, OUT_RESET));
        vecs.push_back(mk("wrm A",        1, 4'h0, 0, 4'hA, 4'h0, -1, 4'h0, OUT_RESET));
        vecs.push_back(mk("rdm A",        1, 4'h9, 0, 4'h3, 4'h0, -1, 4'hA, OUT_RESET));
        vecs.push_back(mk("src chip1",    0, 4'h0, 1, 4'h4, 4'h5, -1, 4'h0, OUT_RESET));
        vecs.push_back(mk("wrm desel",    1, 4'h0, 0, 4'h7, 4'h0, -1, 4'h0, OUT_RESET));
        vecs.push_back(mk("rdm desel",    1, 4'h9, 0, 4'h0, 4'h0, -1, 4'h0, OUT_RESET));
        vecs.push_back(mk("src 1/5 b",    0, 4'h0, 1, 4'h1, 4'h5, -1, 4'h0, OUT_RESET));
        vecs.push_back(mk("rdm kept",     1, 4'h9, 0, 4'h0, 4'h0, -1, 4'hA, OUT_RESET));
        vecs.push_back(mk("sbm",          1, 4'h8, 0, 4'h0, 4'h0, -1, 4'hA, OUT_RESET));
        vecs.push_back(mk("adm",          1, 4'hB, 0, 4'h0, 4'h0, -1, 4'hA, OUT_RESET));
        vecs.push_back(mk("src 2/0",      0, 4'h0, 1, 4'h2, 4'h0, -1, 4'h0, OUT_RESET));
        vecs.push_back(mk("wr2 3",        1, 4'h6, 0, 4'h3, 4'h0, -1, 4'h0, OUT_RESET));
        vecs.push_back(mk("rd2",          1, 4'hE, 0, 4'h0, 4'h0, -1, 4'h3, OUT_RESET));
        vecs.push_back(mk("rd0",          1, 4'hC, 0, 4'h0, 4'h0, -1, 4'h0, OUT_RESET));
        vecs.push_back(mk("wmp 9",        1, 4'h1, 0, 4'h9, 4'h0, -1, 4'h0, 4'h9));
        vecs.push_back(mk("cl_ram",       0, 4'h0, 0, 4'h0, 4'h0,  0, 4'h0, OUT_RESET));
        vecs.push_back(mk("rdm after cl", 1, 4'h9, 0, 4'h0, 4'h0, -1, 4'h0, OUT_RESET));
        vecs.push_back(mk("src 1/5 c",    0, 4'h0, 1, 4'h1, 4'h5, -1, 4'h0, OUT_RESET));
        vecs.push_back(mk("rdm resel",    1, 4'h9, 0, 4'h0, 4'h0, -1, 4'hA, OUT_RESET));
        vecs.push_back(mk("wmp 9 b",      1, 4'h1, 0, 4'h9, 4'h0, -1, 4'h0, 4'h9));
        vecs.push_back(mk("wmp vs cl",    1, 4'h1, 0, 4'hC, 4'h0,  6, 4'h0, OUT_RESET));
        vecs.push_back(mk("src 1/5 d",    0, 4'h0, 1, 4'h1, 4'h5, -1, 4'h0, OUT_RESET));
        vecs.push_back(mk("src+wrm",      1, 4'h0, 1, 4'h1, 4'h5, -1, 4'h0, OUT_RESET));
        vecs.push_back(mk("rdm no wr",    1, 4'h9, 0, 4'h0, 4'h0, -1, 4'hA, OUT_RESET));
        vecs.push_back(mk("rdr",          1, 4'hA, 0, 4'h0, 4'h0, -1, 4'h0, OUT_RESET));
        vecs.push_back(mk("wrr",          1, 4'h2, 0, 4'hF, 4'h0, -1, 4'h0, OUT_RESET));
        vecs.push_back(mk("wpm",          1, 4'h3, 0, 4'hF, 4'h0, -1, 4'h0, OUT_RESET));
        vecs.push_back(mk("rdm final",    1, 4'h9, 0, 4'h0, 4'h0, -1, 4'hA, OUT_RESET));

        for (int i = 0; i < vecs.size(); i++) begin
            instr(vecs[i].name, vecs[i].cm_m2, vecs[i].opa, vecs[i].cm_x2, vecs[i].x2,
                  vecs[i].x3, vecs[i].clr_ph, 1'b1, vecs[i].exp_dbus);
            check({vecs[i].name, " io_out"}, bus_if.io_out, vecs[i].exp_io);
        end

        // Early sync in the third cycle must realign the next cycle to A1.
        step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
        instr("rdm resync", 1, 4'h9, 0, 4'h0, 4'h0, -1, 1'b1, 4'hA);

        // Reset in X1 of a WRM: the write must never land.
        instr("src 3/9", 0, 4'h0, 1, 4'h3, 4'h9, -1, 1'b1, 4'h0);
        for (int p = 0; p < 5; p++) begin
            step(1'b0, 1'b0, p == 4, (p == 4) ? 4'h0 : 4'hD, 1'b0);
        end
        step(1'b0, 1'b0, 1'b0, 4'hD, 1'b1);
        check("rst mid io_out", bus_if.io_out, OUT_RESET);
        instr("src 3/9 b", 0, 4'h0, 1, 4'h3, 4'h9, -1, 1'b1, 4'h0);
        instr("rdm aborted", 1, 4'h9, 0, 4'hD, 4'h0, -1, 1'b1, 4'h0);
        instr("src 1/5 e", 0, 4'h0, 1, 4'h1, 4'h5, -1, 1'b1, 4'h0);
        instr("rdm wiped", 1, 4'h9, 0, 4'h0, 4'h0, -1, 1'b1, 4'h0);

        model_reset();
        m_sel = 1'b1;
        m_reg = 2'd1;
        m_chr = 4'd5;
        for (int n = 0; n < 300; n++) begin
            int         k;
            logic       cm_m2, cm_x2, clr, sync_en;
            logic [3:0] opa, x2, x3, exp_dbus;
            k       = $urandom_range(0, 99);
            cm_m2   = 1'b0;
            cm_x2   = 1'b0;
            opa     = 4'($urandom_range(0, 15));
            x2      = 4'($urandom_range(0, 15));
            x3      = 4'($urandom_range(0, 15));
            clr     = ($urandom_range(0, 19) == 0);
            sync_en = ($urandom_range(0, 3) != 0);
            if (k < 30) begin
                cm_x2 = 1'b1;
                if ($urandom_range(0, 3) != 0) x2[3:2] = CHIP_ID;
            end else if (k < 85) begin
                cm_m2 = 1'b1;
            end else if (k < 90) begin
                cm_m2 = 1'b1;
                cm_x2 = 1'b1;
            end
            model_instr(cm_m2, opa, cm_x2, x2, x3, clr, exp_dbus);
            instr("rand", cm_m2, opa, cm_x2, x2, x3, clr ? 0 : -1, sync_en, exp_dbus);
            check("rand io_out", bus_if.io_out, m_io);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/i4002_ram.md
Name: i4002_ram

Overview:
- MCS-4 data RAM plus 4-bit output port, peer of the ROM chips on the shared 4-bit data bus.
- Consumes the CPU's SRC and I/O command stream on the same bus and reuses the same 8-phase timing regeneration from sync.
- Stores 4 registers x 16 main characters plus 4 registers x 4 status characters, all 4-bit.
- Drives dbus_out during X2 of read commands. Latches io_out on WMP.

Parameters:
- CHIP_ID, 2'b00, chip number matched against bits [3:2] of the SRC X2 nibble.
- OUT_RESET, 4'h0, value loaded into io_out on rst or cl_ram.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- sync  in  1  high for one clk in X3; the next cycle is A1
- cl_ram  in  1  synchronous clear of the output port and SRC selection
- cm_ram  in  1  RAM command line for this bank
- dbus_in  in  4  data bus from the CPU
- dbus_out  out  4  data bus to the CPU; '0 when not driving
- io_out  out  4  output port

Behaviour:
- Timing:
  - 3-bit phase counter: forced to 0 (A1) the cycle after sync, else increments.
  - Phases 0..7 = A1 A2 A3 M1 M2 X1 X2 X3.
  - Without sync the counter wraps 7->0.
- SRC capture:
  - At X2 with cm_ram=1: selected <= (dbus_in[3:2]==CHIP_ID); reg_sel <= dbus_in[1:0].
  - At X3 of the same instruction, if an X2 capture occurred: char_sel <= dbus_in.
  - Selection holds until the next SRC, cl_ram or rst.
  - An SRC addressed to another chip clears selected.
- Command capture:
  - At M2: io_cmd <= cm_ram; opa <= dbus_in (captured every instruction).
  - io_cmd thus self-clears on any instruction without cm_ram at M2.
- Execute at X2 when io_cmd && selected:
  - opa 0 WRM: main[reg_sel][char_sel] <= dbus_in.
  - opa 1 WMP: io_out <= dbus_in.
  - opa 4..7 WR0..WR3: status[reg_sel][opa[1:0]] <= dbus_in.
  - opa 8 SBM, 9 RDM, B ADM: dbus_out = main[reg_sel][char_sel].
  - opa C..F RD0..RD3: dbus_out = status[reg_sel][opa[1:0]].
  - opa 2 WRR, 3 WPM, A RDR: ignored; dbus_out='0, no state change.
- dbus_out:
  - Combinational from phase, io_cmd, selected and opa; valid only during X2.
  - '0 in every other phase and whenever not selected.
  - Memory read is asynchronous from flops, so data is valid in the same X2 cycle.
- Writes take effect at the clk edge ending X2; a read in the next instruction returns the new value.
- cm_ram at X2 in an instruction that also had io_cmd: treated as SRC capture only; the I/O execute is suppressed. Both M2 and X2 CM is illegal CPU behaviour, so the SRC wins deterministically.
- Reset (rst): clears on the next edge; rst has priority over everything.
  - Phase counter 0; io_out=OUT_RESET; selected=0, reg_sel=0, char_sel=0.
  - io_cmd=0, opa=0; all main and status characters 0.
- cl_ram: io_out=OUT_RESET and selected=0. Memory is not cleared.
- If a WMP execute coincides with cl_ram, cl_ram wins.
- rst mid-instruction aborts any pending write; no partial state survives.

Optional Feature:
- Macro: I4002_DBG_EN
- Defined: adds ports dbg_addr in 7 and dbg_data out 4, a host readback path for the PYNQ overlay.
  - dbg_addr[6]=0: main[dbg_addr[5:4]][dbg_addr[3:0]].
  - dbg_addr[6]=1: status[dbg_addr[3:2]][dbg_addr[1:0]]; dbg_addr[5:4] ignored.
  - dbg_data is registered: 1-clk latency, reset 0.
  - Read-only; no effect on bus behaviour.
- Undefined: the ports and the logic do not exist.

Test Plan:
- rst, then RDM with CHIP_ID=0 after SRC 0x0/0x0 -> dbus_out=0 at X2; io_out=OUT_RESET.
- SRC X2=0x1 (chip 0, reg 1), X3=0x5; WRM with 0xA; then RDM -> dbus_out=0xA at X2 only, '0 in all other phases.
- SRC to chip 1 (X2=0x4) with CHIP_ID=0; WRM 0x7; then RDM -> no write, dbus_out='0. Reselecting chip 0 reg1/char5 still reads 0xA.
- WR2 with 0x3 after SRC reg 2; then RD2 -> 0x3. RD0 -> 0.
- WMP with 0x9 -> io_out=0x9 after the X2 edge. Pulse cl_ram -> io_out=OUT_RESET. A following RDM returns '0 until a new SRC.
- Assert rst during X1 of a WRM instruction -> the write is lost; a subsequent read of that address returns 0.
